skip_mode_ctrl: RTL and testbench
=================================

SKIP_MODE_CTRL -- requirements
Module: skip_mode_ctrl

Interface
REQ-001 The block SHALL have parameter LINE_W, default 12, setting the width of the active-line counter and status.
REQ-002 The block SHALL have parameter FRAME_W, default 16, setting the width of the frame counter.
REQ-003 Ports SHALL be as follows (clock and reset first):
- clock  input  1  single clock for all logic.
- reset_n  input  1  asynchronous, active-low reset.
- vs_i  input  1  vertical sync, active high, same timing as the line-skip datapath input.
- de_i  input  1  data enable, same timing as the datapath input.
- cfg_valid_i  input  1  mode request valid.
- cfg_ready_o  output  1  mode request ready.
- cfg_mode_i  input  8  requested image mode; bit0=1 passes all lines, bit0=0 selects 1-of-2 line skip.
- cfg_hold_i  input  8  number of frame ticks to hold the new mode before another request is accepted.
- image_mode_o  output  8  mode driven to the datapath image_mode_i.
- mode_commit_o  output  1  one-cycle pulse when image_mode_o updates.
- busy_o  output  1  high when state is not IDLE.
- frame_cnt_o  output  FRAME_W  count of vs rising edges.
- line_cnt_o  output  LINE_W  number of active lines in the last complete frame.

Function
REQ-004 The block SHALL register vs_i and de_i once (vs_d, de_d). vs_rise = !vs_d & vs_i. vs_fall (the frame tick) = vs_d & !vs_i. de_fall = de_d & !de_i.
REQ-005 The block SHALL implement the states IDLE, PENDING and HOLD. cfg_ready_o SHALL equal (state==IDLE), and busy_o SHALL equal (state!=IDLE).
REQ-006 In IDLE, when cfg_valid_i & cfg_ready_o, the block SHALL capture cfg_mode_i and cfg_hold_i into pending registers and go to PENDING.
REQ-007 In PENDING, at a frame tick, the block SHALL load image_mode_o from the pending mode and pulse mode_commit_o high for exactly one cycle.
REQ-008 On that same frame tick, the block SHALL go to IDLE if the pending hold is 0. Otherwise it SHALL load the hold counter with the pending hold and go to HOLD.
REQ-009 Commit SHALL occur only at a frame tick, so image_mode_o is stable for at least the whole vs-low interval before the next vs_rise, when the datapath latches it.
REQ-010 In HOLD, the block SHALL decrement the hold counter on each frame tick. The tick that takes the counter from 1 to 0 SHALL return the state to IDLE. No other event changes the HOLD state.
REQ-011 If a request is accepted in IDLE on the same cycle as a frame tick, the block SHALL NOT commit on that tick. The commit SHALL occur at the next frame tick.
REQ-012 When cfg_valid_i is high and cfg_ready_o is low, the request SHALL be ignored, with no capture and no state change. The requester holds it until ready.
REQ-013 Frame counter: frame_cnt_o SHALL increment by 1 on each vs_rise and wrap modulo 2^FRAME_W.
REQ-014 Line counter: an internal counter SHALL increment on each de_fall, saturating at 2^LINE_W-1.
REQ-015 On vs_rise, line_cnt_o SHALL load the internal count, and the internal count SHALL be cleared to 0. If de_fall occurs on the same cycle as vs_rise, it SHALL be counted into the new frame, so the internal count becomes 1.
REQ-016 image_mode_o SHALL change only on a commit. A commit of a mode equal to the current mode SHALL still pulse mode_commit_o.

Reset
REQ-017 While reset_n is low, all registers SHALL clear asynchronously: state=IDLE, vs_d=0, de_d=0, image_mode_o=0, mode_commit_o=0, frame_cnt_o=0, line_cnt_o=0, internal counters=0, pending registers=0.
REQ-018 As a result of reset, cfg_ready_o SHALL be 1 and busy_o SHALL be 0.
REQ-019 A reset asserted in PENDING or HOLD SHALL discard the pending request and the hold count. image_mode_o SHALL return to 0 (skip mode).

Verification
REQ-020 Accept mode 0x01 with hold 0 mid-frame, then vs pulse -> mode_commit_o pulses one cycle after vs falls; image_mode_o=0x01; cfg_ready_o=1 on the following cycle.
REQ-021 Accept mode 0x00 with hold 3 -> after commit, busy_o stays high for 3 further frame ticks; ready returns on the 3rd tick; a request during HOLD is not accepted (image_mode_o unchanged).
REQ-022 Frame with 1080 de pulses, then vs_rise -> line_cnt_o=1080; next frame with 540 de pulses -> line_cnt_o=540; frame_cnt_o increments by 1 per frame.
REQ-023 cfg_valid_i asserted on the exact frame-tick cycle in IDLE -> no commit on that tick; commit on the following tick.
REQ-024 reset_n pulsed low while in HOLD with image_mode_o=0x01 -> all outputs return to their reset values immediately; cfg_ready_o=1 after release.
REQ-025 Frame counter preloaded near wrap (run 65536 frames, or FRAME_W=4 with 16 frames) -> frame_cnt_o wraps to 0 with no glitch on the other outputs.

Source files
------------

// File: rtl/skip_mode_ctrl.sv
// skip_mode_ctrl: frame-synchronous image-mode controller for the line-skip datapath.
// Accepts a mode request, commits it on the next vs falling edge (frame tick),
// optionally locks out further requests for a number of frame ticks, and keeps
// frame / active-line statistics.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a mode request
// PENDING | request captured, waiting for the next frame tick to commit
// HOLD    | mode committed, counting frame ticks before accepting again

module skip_mode_ctrl #(
  parameter int LINE_W  = 12,
  parameter int FRAME_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               vs_i,
  input  logic               de_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [7:0]         cfg_mode_i,
  input  logic [7:0]         cfg_hold_i,
  output logic [7:0]         image_mode_o,
  output logic               mode_commit_o,
  output logic               busy_o,
  output logic [FRAME_W-1:0] frame_cnt_o,
  output logic [LINE_W-1:0]  line_cnt_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  localparam logic [LINE_W-1:0]  LINE_ONE  = LINE_W'(1);
  localparam logic [LINE_W-1:0]  LINE_MAX  = '1;
  localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

  logic               r_vs_d;
  logic               r_de_d;
  logic [1:0]         r_state;
  logic [7:0]         r_pend_mode;
  logic [7:0]         r_pend_hold;
  logic [7:0]         r_hold_cnt;
  logic [7:0]         r_image_mode;
  logic               r_commit;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [LINE_W-1:0]  r_line_int;
  logic [LINE_W-1:0]  r_line_cnt;

  logic w_vs_rise;
  logic w_tick;
  logic w_de_fall;
  logic w_accept;

  assign w_vs_rise = !r_vs_d && vs_i;
  assign w_tick    = r_vs_d && !vs_i;
  assign w_de_fall = r_de_d && !de_i;
  assign w_accept  = cfg_valid_i && (r_state == ST_IDLE);

  assign cfg_ready_o   = (r_state == ST_IDLE);
  assign busy_o        = (r_state != ST_IDLE);
  assign image_mode_o  = r_image_mode;
  assign mode_commit_o = r_commit;
  assign frame_cnt_o   = r_frame_cnt;
  assign line_cnt_o    = r_line_cnt;

  // Single-stage delay of vs/de for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
    end else begin
      r_vs_d <= vs_i;
      r_de_d <= de_i;
    end
  end

  // Request / commit / hold sequencing. A request accepted on a tick cycle is
  // only in PENDING after that edge, so it naturally commits on the next tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_pend_mode  <= 8'd0;
      r_pend_hold  <= 8'd0;
      r_hold_cnt   <= 8'd0;
      r_image_mode <= 8'd0;
      r_commit     <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pend_mode <= cfg_mode_i;
            r_pend_hold <= cfg_hold_i;
            r_state     <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (w_tick) begin
            r_image_mode <= r_pend_mode;
            r_commit     <= 1'b1;
            if (r_pend_hold == 8'd0) begin
              r_state <= ST_IDLE;
            end else begin
              r_hold_cnt <= r_pend_hold;
              r_state    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
            // <= 1 so a corrupted zero count cannot trap the FSM for 256 frames
            if (r_hold_cnt <= 8'd1) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Frame counter: one count per vs rising edge, free-running wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= '0;
    end else if (w_vs_rise) begin
      r_frame_cnt <= r_frame_cnt + FRAME_ONE;
    end
  end

  // Active-line counter: saturating count of de falls, published at vs rise.
  // A de fall coincident with vs rise belongs to the new frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_line_int <= '0;
      r_line_cnt <= '0;
    end else if (w_vs_rise) begin
      r_line_cnt <= r_line_int;
      r_line_int <= w_de_fall ? LINE_ONE : '0;
    end else if (w_de_fall && (r_line_int != LINE_MAX)) begin
      r_line_int <= r_line_int + LINE_ONE;
    end
  end

endmodule

// File: tb/tb_skip_mode_ctrl.sv
// Bench for skip_mode_ctrl: expected committed modes go into a scoreboard
// queue when requests are issued and are popped by a monitor on each commit
// pulse; frame/line statistics are checked against a small bench-side model.

module tb_skip_mode_ctrl;

  localparam int LW = 12;
  localparam int FW = 4;
  localparam int LINE_SAT = (1 << LW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          vs_i = 1'b0;
  logic          de_i = 1'b0;
  logic          cfg_valid_i = 1'b0;
  logic          cfg_ready_o;
  logic [7:0]    cfg_mode_i = 8'd0;
  logic [7:0]    cfg_hold_i = 8'd0;
  logic [7:0]    image_mode_o;
  logic          mode_commit_o;
  logic          busy_o;
  logic [FW-1:0] frame_cnt_o;
  logic [LW-1:0] line_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]    exp_q[$];
  logic [FW-1:0] exp_frame = '0;
  int            cur_lines = 0;
  int            exp_line  = 0;

  skip_mode_ctrl #(.LINE_W(LW), .FRAME_W(FW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .vs_i          (vs_i),
    .de_i          (de_i),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_ready_o   (cfg_ready_o),
    .cfg_mode_i    (cfg_mode_i),
    .cfg_hold_i    (cfg_hold_i),
    .image_mode_o  (image_mode_o),
    .mode_commit_o (mode_commit_o),
    .busy_o        (busy_o),
    .frame_cnt_o   (frame_cnt_o),
    .line_cnt_o    (line_cnt_o)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Scoreboard: every commit pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    if (reset_n && mode_commit_o) begin
      if (exp_q.size() == 0) check_val("unexpected_commit", 1, 0);
      else check_val("commit_mode", int'(image_mode_o), int'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_req(input logic [7:0] m, input logic [7:0] h);
    check_val("ready_before_req", int'(cfg_ready_o), 1);
    cfg_valid_i = 1'b1; cfg_mode_i = m; cfg_hold_i = h;
    exp_q.push_back(m);
    tick();
    cfg_valid_i = 1'b0;
    check_val("busy_after_req", int'(busy_o), 1);
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      de_i = 1'b1; tick();
      de_i = 1'b0; tick();
      if (cur_lines < LINE_SAT) cur_lines++;
    end
  endtask

  // vs pulse; optional de fall on the vs-rise cycle, optional request on the tick cycle.
  task automatic vs_pulse(input bit co_de, input bit req, input logic [7:0] m, input logic [7:0] h);
    vs_i = 1'b1;
    if (co_de) de_i = 1'b0;
    tick();
    exp_frame = exp_frame + 1'b1;
    exp_line  = cur_lines;
    cur_lines = co_de ? 1 : 0;
    check_val("frame_cnt", int'(frame_cnt_o), int'(exp_frame));
    check_val("line_cnt", int'(line_cnt_o), exp_line);
    tick();
    vs_i = 1'b0;
    if (req) begin
      check_val("ready_on_tick_req", int'(cfg_ready_o), 1);
      cfg_valid_i = 1'b1; cfg_mode_i = m; cfg_hold_i = h;
      exp_q.push_back(m);
    end
    tick();
    cfg_valid_i = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check_val("rst_ready", int'(cfg_ready_o), 1);
    check_val("rst_busy", int'(busy_o), 0);
    check_val("rst_mode", int'(image_mode_o), 0);
    check_val("rst_commit", int'(mode_commit_o), 0);
    check_val("rst_frame", int'(frame_cnt_o), 0);
    check_val("rst_line", int'(line_cnt_o), 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Mode 0x01, hold 0, requested mid-frame
    lines(3);
    send_req(8'h01, 8'h00);
    lines(2);
    check_val("mode_before_tick", int'(image_mode_o), 0);
    vs_pulse(1'b0, 1'b0, 8'h00, 8'h00);
    check_val("commit_pulse", int'(mode_commit_o), 1);
    check_val("mode_after_commit", int'(image_mode_o), 1);
    check_val("ready_after_hold0", int'(cfg_ready_o), 1);
    tick();
    check_val("commit_one_cycle", int'(mode_commit_o), 0);

    // Mode 0x00, hold 3; a request during HOLD is ignored
    send_req(8'h00, 8'h03);
    vs_pulse(1'b0, 1'b0, 8'h00, 8'h00);
    check_val("mode_hold3", int'(image_mode_o), 0);
    check_val("busy_hold_t0", int'(busy_o), 1);
    cfg_valid_i = 1'b1; cfg_mode_i = 8'h55; cfg_hold_i = 8'h00;
    tick();
    check_val("ready_in_hold", int'(cfg_ready_o), 0);
    lines(2);
    vs_pulse(1'b0, 1'b0, 8'h00, 8'h00);
    cfg_valid_i = 1'b0;
    check_val("busy_hold_t1", int'(busy_o), 1);
    vs_pulse(1'b0, 1'b0, 8'h00, 8'h00);
    check_val("busy_hold_t2", int'(busy_o), 1);
    vs_pulse(1'b0, 1'b0, 8'h00, 8'h00);
    check_val("ready_hold_t3", int'(cfg_ready_o), 1);
    check_val("mode_unchanged_hold", int'(image_mode_o), 0);

    // Request on the exact tick cycle commits one tick later
    vs_pulse(1'b0, 1'b1, 8'h01, 8'h00);
    check_val("no_commit_on_req_tick", int'(mode_commit_o), 0);
    check_val("pending_after_tick_req", int'(busy_o), 1);
    lines(1);
    vs_pulse(1'b0, 1'b0, 8'h00, 8'h00);
    check_val("late_commit_pulse", int'(mode_commit_o), 1);
    check_val("late_commit_mode", int'(image_mode_o), 1);

    // Line counting, coincident de fall, saturation
    lines(1080);
    vs_pulse(1'b0, 1'b0, 8'h00, 8'h00);
    lines(540);
    vs_pulse(1'b0, 1'b0, 8'h00, 8'h00);
    lines(3);
    de_i = 1'b1; tick();
    vs_pulse(1'b1, 1'b0, 8'h00, 8'h00);
    lines(2);
    vs_pulse(1'b0, 1'b0, 8'h00, 8'h00);
    lines(LINE_SAT + 5);
    vs_pulse(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset while in HOLD with mode 0x01
    send_req(8'h01, 8'h02);
    vs_pulse(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check_val("hold_before_rst", int'(busy_o), 1);
    check_val("mode_before_rst", int'(image_mode_o), 1);
    #2 reset_n = 1'b0;
    #1;
    check_val("arst_mode", int'(image_mode_o), 0);
    check_val("arst_busy", int'(busy_o), 0);
    check_val("arst_ready", int'(cfg_ready_o), 1);
    check_val("arst_frame", int'(frame_cnt_o), 0);
    check_val("arst_line", int'(line_cnt_o), 0);
    check_val("arst_commit", int'(mode_commit_o), 0);
    exp_frame = '0; cur_lines = 0; exp_line = 0;
    tick();
    reset_n = 1'b1;
    tick();
    check_val("ready_after_rst", int'(cfg_ready_o), 1);

    // Frame counter wrap (16 frames at FRAME_W=4), no side effects
    for (int f = 0; f < 16; f++) begin
      lines(1);
      vs_pulse(1'b0, 1'b0, 8'h00, 8'h00);
      check_val("wrap_mode", int'(image_mode_o), 0);
      check_val("wrap_busy", int'(busy_o), 0);
    end
    check_val("frame_wrapped", int'(frame_cnt_o), 0);

    tick();
    tick();
    check_val("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
